// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with a synchronous parallel load.
// out steps through 0..N-1 in either direction. Values at or above N
// never appear on out: an out-of-range load clamps to N-1 and raises a
// one-cycle load_err pulse. wrap pulses in the cycle out first shows a
// wrapped value, and wrap_cnt tallies those wraps, saturating at all-ones.
// The terminal count tc is combinational and follows up_dn at once.
// mod_n_updown_counter_chk is a passive checker. Instantiate it beside
// the counter in simulation; it is not part of the synthesised datapath.

module mod_n_updown_counter #(
   parameter int N      = 10,
   parameter int WIDTH  = 4,
   parameter int WCNT_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              up_dn,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  out,
   output logic              tc,
   output logic              wrap,
   output logic              load_err,
   output logic [WCNT_W-1:0] wrap_cnt
);

   // Largest legal count. WIDTH bits always hold N-1.
   localparam logic [WIDTH-1:0]  MAX_V    = WIDTH'(N - 1);
   localparam logic [WIDTH-1:0]  ZERO_V   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]  ONE_V    = WIDTH'(1);
   // N needs one more bit than the count when N == 2**WIDTH.
   localparam logic [WIDTH:0]    N_EXT    = (WIDTH + 1)'(N);
   localparam logic [WCNT_W-1:0] WCNT_MAX = {WCNT_W{1'b1}};
   localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

   logic [WIDTH-1:0]  out_r;
   logic              wrap_r;
   logic              load_err_r;
   logic [WCNT_W-1:0] wrap_cnt_r;

   logic [WIDTH-1:0]  out_nxt_s;
   logic              wrap_nxt_s;
   logic              load_err_nxt_s;
   logic [WCNT_W-1:0] wrap_cnt_nxt_s;
   logic              load_ok_s;
   logic              at_max_s;
   logic              at_zero_s;

   // Range test on load_val, done one bit wider so that N == 2**WIDTH is handled.
   assign load_ok_s = ({1'b0, load_val} < N_EXT);
   assign at_max_s  = (out_r == MAX_V);
   assign at_zero_s = (out_r == ZERO_V);

   // Next-state selection. Load has priority over a count step, and a count step over hold.
   always_comb begin
      out_nxt_s      = out_r;
      wrap_nxt_s     = 1'b0;
      load_err_nxt_s = 1'b0;
      if (load) begin
         if (load_ok_s) begin
            out_nxt_s      = load_val;
            load_err_nxt_s = 1'b0;
         end else begin
            out_nxt_s      = MAX_V;
            load_err_nxt_s = 1'b1;
         end
      end else if (en) begin
         if (up_dn) begin
            if (at_max_s) begin
               out_nxt_s  = ZERO_V;
               wrap_nxt_s = 1'b1;
            end else begin
               out_nxt_s  = out_r + ONE_V;
               wrap_nxt_s = 1'b0;
            end
         end else begin
            if (at_zero_s) begin
               out_nxt_s  = MAX_V;
               wrap_nxt_s = 1'b1;
            end else begin
               out_nxt_s  = out_r - ONE_V;
               wrap_nxt_s = 1'b0;
            end
         end
      end else begin
         out_nxt_s  = out_r;
         wrap_nxt_s = 1'b0;
      end
   end

   // Saturating wrap tally. It advances on the same edge that raises wrap.
   always_comb begin
      wrap_cnt_nxt_s = wrap_cnt_r;
      if (wrap_nxt_s && (wrap_cnt_r != WCNT_MAX)) begin
         wrap_cnt_nxt_s = wrap_cnt_r + WCNT_ONE;
      end else begin
         wrap_cnt_nxt_s = wrap_cnt_r;
      end
   end

   // State registers. Reset clears them at once, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_r      <= ZERO_V;
         wrap_r     <= 1'b0;
         load_err_r <= 1'b0;
         wrap_cnt_r <= {WCNT_W{1'b0}};
      end else begin
         out_r      <= out_nxt_s;
         wrap_r     <= wrap_nxt_s;
         load_err_r <= load_err_nxt_s;
         wrap_cnt_r <= wrap_cnt_nxt_s;
      end
   end

   // tc depends on the live direction input, so a direction change moves it without a clock.
   assign tc       = up_dn ? at_max_s : at_zero_s;
   assign out      = out_r;
   assign wrap     = wrap_r;
   assign load_err = load_err_r;
   assign wrap_cnt = wrap_cnt_r;

endmodule

// Passive property checker for mod_n_updown_counter.
module mod_n_updown_counter_chk #(
   parameter int N      = 10,
   parameter int WIDTH  = 4,
   parameter int WCNT_W = 8
) (
   input logic              clk,
   input logic              rstn,
   input logic [WIDTH-1:0]  out,
   input logic              wrap,
   input logic [WCNT_W-1:0] wrap_cnt
);

   localparam logic [WIDTH:0]   N_EXT = (WIDTH + 1)'(N);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(N - 1);

   // out must always stay inside 0..N-1.
   a_out_range: assert property (@(posedge clk) disable iff (!rstn)
      ({1'b0, out} < N_EXT));

   // A wrapped value can only be 0 (after counting up) or N-1 (after counting down).
   a_wrap_value: assert property (@(posedge clk) disable iff (!rstn)
      wrap |-> ((out == {WIDTH{1'b0}}) || (out == MAX_V)));

   // Outside reset, the tally never moves backwards.
   a_wcnt_mono: assert property (@(posedge clk) disable iff (!rstn)
      (wrap_cnt >= $past(wrap_cnt)));

endmodule
